// File: rtl/pipe_mon_pkg.sv
// pipe_mon_pkg: shared monitor state encoding and event channel indices
package pipe_mon_pkg;
  typedef enum logic [1:0] {MON_IDLE, MON_RUN, MON_HALTED} mon_state_e;
  localparam int EV_STALL   = 0;
  localparam int EV_FLUSH   = 1;
  localparam int EV_RETIRE  = 2;
  localparam int EV_LOADUSE = 3;
endpackage

// File: rtl/pipe_event_monitor_if.sv
// pipe_event_monitor_if: control, event strobes and readout of the pipeline monitor
//   master: drives start/event/clear/snap/sel, observes cnt/cycle/snap_valid/halt/running
//   slave : the monitor itself
interface pipe_event_monitor_if #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_W      = 32,
  parameter int SEL_W      = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1
);
  logic                  start_i;
  logic [NUM_EVENTS-1:0] event_i;
  logic                  clear_i;
  logic                  snap_i;
  logic [SEL_W-1:0]      sel_i;
  logic [CNT_W-1:0]      cnt_o;
  logic [CNT_W-1:0]      cycle_o;
  logic                  snap_valid_o;
  logic                  halt_o;
  logic                  running_o;
  modport master (
    output start_i, event_i, clear_i, snap_i, sel_i,
    input  cnt_o, cycle_o, snap_valid_o, halt_o, running_o
  );
  modport slave (
    input  start_i, event_i, clear_i, snap_i, sel_i,
    output cnt_o, cycle_o, snap_valid_o, halt_o, running_o
  );
endinterface

// File: rtl/pipe_event_monitor_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear
//   clk_i clock, rst_i sync active-low reset, clr_i clear, inc_i increment, q_o count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] q_q, q_d;
  always_comb q_d = clr_i ? '0 : inc_i && !(&q_q) ? q_q + W'(1) : q_q;
  always_ff @(posedge clk_i)
    if (!rst_i) q_q <= '0;
    else q_q <= q_d;
  assign q_o = q_q;
endmodule

// File: rtl/pipe_event_monitor.sv
// pipe_event_monitor: run-cycle and per-event counters with snapshot readout and cycle-limit halt
//   clk_i clock, rst_i sync active-low reset
//   mon: start_i/event_i/clear_i/snap_i/sel_i in; cnt_o (shadow of sel_i), cycle_o,
//        snap_valid_o, halt_o, running_o out
module pipe_event_monitor import pipe_mon_pkg::*; #(
  parameter int          NUM_EVENTS  = 4,
  parameter int          CNT_W       = 32,
  parameter int unsigned CYCLE_LIMIT = 30,
  parameter int          SEL_W       = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1
) (
  input logic                 clk_i,
  input logic                 rst_i,
  pipe_event_monitor_if.slave mon
);
  mon_state_e                          state_q, state_d;
  logic                                halt_q, running_q, snap_valid_q, count_en, limit_hit;
  logic [NUM_EVENTS:0]                 inc;
  logic [NUM_EVENTS:0][CNT_W-1:0]      q, nxt;
  logic [NUM_EVENTS-1:0][CNT_W-1:0]    shadow_q;
  // the start edge itself counts, so IDLE with start_i high is a counting cycle
  assign count_en = state_q == MON_RUN || (state_q == MON_IDLE && mon.start_i);
  // top slot is the cycle counter, lower slots are the event channels
  assign inc = {count_en, {NUM_EVENTS{count_en}} & mon.event_i};
  for (genvar g = 0; g <= NUM_EVENTS; g++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i,
      .rst_i,
      .clr_i (mon.clear_i),
      .inc_i (inc[g]),
      .q_o   (q[g])
    );
    // post-edge value, so a snapshot includes this cycle's events
    assign nxt[g] = inc[g] && !(&q[g]) ? q[g] + CNT_W'(1) : q[g];
  end
  // compared at full width so a narrow counter cannot alias a larger limit
  assign limit_hit = CYCLE_LIMIT != 0 && count_en && 64'(nxt[NUM_EVENTS]) == 64'(CYCLE_LIMIT);
  always_comb
    state_d = limit_hit                              ? MON_HALTED :
              state_q == MON_IDLE && mon.start_i     ? MON_RUN    :
              state_q == MON_RUN  && !mon.start_i    ? MON_IDLE   : state_q;
  always_ff @(posedge clk_i)
    if (!rst_i || mon.clear_i) begin
      state_q      <= MON_IDLE;
      halt_q       <= 1'b0;
      running_q    <= 1'b0;
      snap_valid_q <= 1'b0;
      shadow_q     <= '0;
    end else begin
      state_q      <= state_d;
      halt_q       <= state_d == MON_HALTED;
      running_q    <= state_d == MON_RUN;
      snap_valid_q <= snap_valid_q || mon.snap_i;
      shadow_q     <= mon.snap_i ? nxt[NUM_EVENTS-1:0] : shadow_q;
    end
  assign mon.cnt_o        = 32'(mon.sel_i) < NUM_EVENTS ? shadow_q[mon.sel_i] : '0;
  assign mon.cycle_o      = q[NUM_EVENTS];
  assign mon.snap_valid_o = snap_valid_q;
  assign mon.halt_o       = halt_q;
  assign mon.running_o    = running_q;
endmodule

// File: tb/tb_pipe_event_monitor.sv
// tb_pipe_event_monitor: scoreboard bench driving a 32-bit/limit-30 monitor and a 4-bit/no-limit monitor in lockstep
module tb_pipe_event_monitor;
  import pipe_mon_pkg::*;
  typedef struct packed {
    logic [1:0]       st;
    logic             sv;
    logic [63:0]      cyc;
    logic [3:0][63:0] ev;
    logic [3:0][63:0] sh;
  } mdl_t;
  typedef struct packed {
    logic [63:0] cyc;
    logic        halt;
    logic        run;
    logic        sv;
    logic [63:0] cnt;
  } exp_t;
  localparam logic [3:0] E_STALL  = 4'(1 << EV_STALL);
  localparam logic [3:0] E_FLUSH  = 4'(1 << EV_FLUSH);
  localparam logic [3:0] E_RETIRE = 4'(1 << EV_RETIRE);
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;
  mdl_t ma = '0;
  mdl_t mb = '0;
  exp_t qa[$];
  exp_t qb[$];
  pipe_event_monitor_if #(.NUM_EVENTS(4), .CNT_W(32), .SEL_W(2)) ifa ();
  pipe_event_monitor_if #(.NUM_EVENTS(4), .CNT_W(4),  .SEL_W(2)) ifb ();
  pipe_event_monitor #(.NUM_EVENTS(4), .CNT_W(32), .CYCLE_LIMIT(30)) dut_a (.clk_i(clk), .rst_i(rst), .mon(ifa));
  pipe_event_monitor #(.NUM_EVENTS(4), .CNT_W(4),  .CYCLE_LIMIT(0))  dut_b (.clk_i(clk), .rst_i(rst), .mon(ifb));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic mdl_t mstep(input mdl_t m, input logic r, input logic s, input logic [3:0] e,
                                 input logic c, input logic sn, input logic [63:0] mx, input logic [63:0] lim);
    mdl_t n = m;
    logic en;
    if (!r || c) return '0;
    en = m.st == MON_RUN || (m.st == MON_IDLE && s);
    if (en) begin
      n.cyc = m.cyc == mx ? mx : m.cyc + 64'd1;
      for (int i = 0; i < 4; i++) if (e[i] && m.ev[i] != mx) n.ev[i] = m.ev[i] + 64'd1;
    end
    if (en && lim != 0 && n.cyc == lim) n.st = MON_HALTED;
    else if (m.st == MON_IDLE && s) n.st = MON_RUN;
    else if (m.st == MON_RUN && !s) n.st = MON_IDLE;
    if (sn) begin
      n.sh = n.ev;
      n.sv = 1'b1;
    end
    return n;
  endfunction
  task automatic step(input logic r, input logic s, input logic [3:0] e, input logic c,
                      input logic sn, input logic [1:0] sl);
    exp_t ea, eb;
    rst = r;
    ifa.start_i = s; ifa.event_i = e; ifa.clear_i = c; ifa.snap_i = sn; ifa.sel_i = sl;
    ifb.start_i = s; ifb.event_i = e; ifb.clear_i = c; ifb.snap_i = sn; ifb.sel_i = sl;
    ma = mstep(ma, r, s, e, c, sn, 64'hFFFF_FFFF, 64'd30);
    mb = mstep(mb, r, s, e, c, sn, 64'd15, 64'd0);
    qa.push_back('{ma.cyc, ma.st == MON_HALTED, ma.st == MON_RUN, ma.sv, ma.sh[sl]});
    qb.push_back('{mb.cyc, mb.st == MON_HALTED, mb.st == MON_RUN, mb.sv, mb.sh[sl]});
    @(posedge clk);
    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    chk("a.cycle", 64'(ifa.cycle_o), ea.cyc);
    chk("a.halt", 64'(ifa.halt_o), 64'(ea.halt));
    chk("a.running", 64'(ifa.running_o), 64'(ea.run));
    chk("a.snap_valid", 64'(ifa.snap_valid_o), 64'(ea.sv));
    chk("a.cnt", 64'(ifa.cnt_o), ea.cnt);
    chk("b.cycle", 64'(ifb.cycle_o), eb.cyc);
    chk("b.halt", 64'(ifb.halt_o), 64'(eb.halt));
    chk("b.running", 64'(ifb.running_o), 64'(eb.run));
    chk("b.snap_valid", 64'(ifb.snap_valid_o), 64'(eb.sv));
    chk("b.cnt", 64'(ifb.cnt_o), eb.cnt);
  endtask
  initial begin
    ifa.start_i = 0; ifa.event_i = 0; ifa.clear_i = 0; ifa.snap_i = 0; ifa.sel_i = 0;
    ifb.start_i = 0; ifb.event_i = 0; ifb.clear_i = 0; ifb.snap_i = 0; ifb.sel_i = 0;
    for (int i = 0; i < 5; i++) step(0, 0, 4'hF, 0, 0, 2'(i));
    chk("plan.rst_cycle", 64'(ifa.cycle_o), 64'd0);
    for (int i = 0; i < 10; i++) step(1, i < 9, E_STALL | (i % 2 == 0 ? E_FLUSH : 4'd0), 0, 0, 2'(i));
    step(1, 0, 4'hF, 0, 1, 2'd0);
    chk("plan.run10_cycle", 64'(ifa.cycle_o), 64'd10);
    chk("plan.run10_ch0", 64'(ifa.cnt_o), 64'd10);
    step(1, 0, 0, 0, 0, 2'd1);
    chk("plan.run10_ch1", 64'(ifa.cnt_o), 64'd5);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 2'(i));
    step(1, 0, 0, 1, 0, 2'd0);
    for (int i = 0; i < 40; i++) step(1, 1, E_STALL, 0, 0, 2'(i));
    step(1, 0, E_STALL, 0, 1, 2'd0);
    chk("plan.limit_cycle", 64'(ifa.cycle_o), 64'd30);
    chk("plan.limit_halt", 64'(ifa.halt_o), 64'd1);
    chk("plan.limit_ch0", 64'(ifa.cnt_o), 64'd30);
    for (int i = 0; i < 3; i++) step(1, 1, E_STALL, 0, 0, 2'd0);
    step(1, 0, 0, 1, 0, 2'd0);
    for (int i = 0; i < 20; i++) step(1, 1, E_RETIRE, 0, 0, 2'(i));
    step(1, 0, 0, 0, 1, 2'd2);
    chk("plan.sat_ch2", 64'(ifb.cnt_o), 64'd15);
    chk("plan.sat_cycle", 64'(ifb.cycle_o), 64'd15);
    step(1, 0, 0, 1, 0, 2'd0);
    for (int i = 0; i < 3; i++) step(1, 1, 4'($urandom), 0, 0, 2'(i));
    step(1, 0, 0, 0, 1, 2'd3);
    step(1, 1, 4'($urandom), 0, 0, 2'd1);
    step(1, 1, 4'hF, 1, 1, 2'd0);
    chk("plan.clr_cycle", 64'(ifa.cycle_o), 64'd0);
    chk("plan.clr_running", 64'(ifa.running_o), 64'd0);
    chk("plan.clr_snap_valid", 64'(ifa.snap_valid_o), 64'd0);
    step(1, 0, 0, 1, 0, 2'd0);
    for (int i = 0; i < 7; i++) step(1, 1, 4'($urandom), 0, i == 4, 2'(i));
    step(0, 1, 4'hF, 0, 1, 2'd1);
    chk("plan.rst_mid_cycle", 64'(ifa.cycle_o), 64'd0);
    chk("plan.rst_mid_running", 64'(ifa.running_o), 64'd0);
    for (int i = 0; i < 3; i++) step(1, 1, E_FLUSH, 0, i == 2, 2'd1);
    chk("plan.resume_cycle", 64'(ifa.cycle_o), 64'd3);
    chk("plan.resume_ch1", 64'(ifa.cnt_o), 64'd3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
